dtw_mem_arb: RTL and testbench

DTW_MEM_ARB -- requirements
Module: dtw_mem_arb

---
 rtl/dtw_mem_arb.sv | 165 ++++++++++++++++
 tb/tb_dtw_mem_arb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_mem_arb.sv
// dtw_mem_arb: round-robin arbiter with ownership lock between the DTW core and the
// host/loader, driving a single-port synchronous memory with a fixed three-cycle read return.
module dtw_mem_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic        p0_lock,
    input  logic        p1_lock,
    input  logic [9:0]  p0_addr,
    input  logic [9:0]  p1_addr,
    input  logic [31:0] p0_wdata,
    input  logic [31:0] p1_wdata,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [31:0] rdata,
    output logic [9:0]  mem_addr,
    output logic        mem_WR,
    output logic        mem_CS,
    output logic [31:0] mem_wdata,
    output logic        mem_oe,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t      state_q;
    logic        ptr_q, ptr_d;
    logic        tag1Valid_q, tag1Port_q;
    logic        tag2Valid_q, tag2Port_q;
    logic        p0Rvalid_q, p1Rvalid_q;
    logic [31:0] rdata_q;
    logic        memCs_q, memWr_q, memOe_q;
    logic [9:0]  memAddr_q;
    logic [31:0] memWdata_q;

    logic        gnt0, gnt1, anyGnt, gntPort, gntWe;
    logic [9:0]  gntAddr;
    logic [31:0] gntWdata;

    // An owning port shuts the other out entirely; otherwise the pointer breaks ties.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state_q)
                OWN0:    gnt0 = p0_req;
                OWN1:    gnt1 = p1_req;
                default: begin
                    if (p0_req && p1_req) begin
                        gnt0 = ~ptr_q;
                        gnt1 = ptr_q;
                    end else begin
                        gnt0 = p0_req;
                        gnt1 = p1_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        anyGnt   = gnt0 | gnt1;
        gntPort  = gnt1;
        gntWe    = gnt1 ? p1_we    : p0_we;
        gntAddr  = gnt1 ? p1_addr  : p0_addr;
        gntWdata = gnt1 ? p1_wdata : p0_wdata;
        ptr_d    = anyGnt ? ~gntPort : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 && p0_lock) begin
                        state_q <= OWN0;
                    end else if (gnt1 && p1_lock) begin
                        state_q <= OWN1;
                    end
                end
                OWN0: begin
                    if (!p0_req || !p0_lock) begin
                        state_q <= IDLE;
                    end
                end
                OWN1: begin
                    if (!p1_req || !p1_lock) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Address and write data hold across idle cycles; only the strobes fall back.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= 1'b0;
            memCs_q    <= 1'b1;
            memWr_q    <= 1'b0;
            memOe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (anyGnt) begin
                memCs_q    <= 1'b0;
                memWr_q    <= gntWe;
                memOe_q    <= gntWe;
                memAddr_q  <= gntAddr;
                memWdata_q <= gntWdata;
            end else begin
                memCs_q <= 1'b1;
                memWr_q <= 1'b0;
                memOe_q <= 1'b0;
            end
        end
    end

    // Read tags march alongside the memory latency so data returns to the port that asked.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1Valid_q <= 1'b0;
            tag1Port_q  <= 1'b0;
            tag2Valid_q <= 1'b0;
            tag2Port_q  <= 1'b0;
            p0Rvalid_q  <= 1'b0;
            p1Rvalid_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            tag1Valid_q <= anyGnt && !gntWe;
            tag1Port_q  <= gntPort;
            tag2Valid_q <= tag1Valid_q;
            tag2Port_q  <= tag1Port_q;
            p0Rvalid_q  <= tag2Valid_q && !tag2Port_q;
            p1Rvalid_q  <= tag2Valid_q && tag2Port_q;
            if (tag2Valid_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = p0Rvalid_q;
    assign p1_rvalid = p1Rvalid_q;
    assign rdata     = rdata_q;
    assign mem_addr  = memAddr_q;
    assign mem_WR    = memWr_q;
    assign mem_CS    = memCs_q;
    assign mem_wdata = memWdata_q;
    assign mem_oe    = memOe_q;

endmodule

// File: tb/tb_dtw_mem_arb.sv
// Bench for dtw_mem_arb: directed vectors with literal checks, plus a transaction-level
// model of arbitration, memory contents and read return compared every cycle.
module tb_dtw_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock;
    logic [9:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] rdata;
    logic [9:0]  mem_addr;
    logic        mem_WR, mem_CS, mem_oe;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad = 0;

    dtw_mem_arb dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p1_req(p1_req),
        .p0_we(p0_we), .p1_we(p1_we),
        .p0_lock(p0_lock), .p1_lock(p1_lock),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .rdata(rdata),
        .mem_addr(mem_addr), .mem_WR(mem_WR), .mem_CS(mem_CS),
        .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] tbMem [1024];
    logic [31:0] shadow [1024];

    function automatic logic [31:0] initWord(input int i);
        return 32'h5A000000 ^ (i * 32'h00010203);
    endfunction

    // Synchronous single-port memory seen by the arbiter.
    always @(posedge clk) begin
        if (!mem_CS) begin
            if (mem_WR) tbMem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tbMem[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Transaction model: owner (-1 none), round-robin pointer, expected command and read returns.
    logic        modelOn = 1'b0;
    int          mOwner = -1;
    int          mPtr = 0;
    int          cyc = 0;
    logic        eg0, eg1;
    logic        expCs = 1'b1, expWr = 1'b0, expOe = 1'b0;
    logic [9:0]  expAddr = '0;
    logic [31:0] expWdata = '0;
    logic        dueValid [8];
    int          duePort [8];
    logic [31:0] dueData [8];

    initial begin
        @(posedge clk);
        modelOn = 1'b1;
    end

    always @(negedge clk) begin
        if (modelOn) begin
            int s;
            int g;
            s = cyc % 8;
            eg0 = 1'b0;
            eg1 = 1'b0;
            if (!rst) begin
                if (mOwner == -1) begin
                    if (p0_req && p1_req) begin
                        eg0 = (mPtr == 0);
                        eg1 = (mPtr == 1);
                    end else begin
                        eg0 = p0_req;
                        eg1 = p1_req;
                    end
                end else if (mOwner == 0) begin
                    eg0 = p0_req;
                end else begin
                    eg1 = p1_req;
                end
            end
            checkOutput($sformatf("model_p0_gnt@%0d", cyc), 32'(p0_gnt), 32'(eg0));
            checkOutput($sformatf("model_p1_gnt@%0d", cyc), 32'(p1_gnt), 32'(eg1));
            checkOutput($sformatf("model_mem_CS@%0d", cyc), 32'(mem_CS), 32'(expCs));
            checkOutput($sformatf("model_mem_WR@%0d", cyc), 32'(mem_WR), 32'(expWr));
            checkOutput($sformatf("model_mem_oe@%0d", cyc), 32'(mem_oe), 32'(expOe));
            checkOutput($sformatf("model_mem_addr@%0d", cyc), 32'(mem_addr), 32'(expAddr));
            checkOutput($sformatf("model_mem_wdata@%0d", cyc), mem_wdata, expWdata);
            checkOutput($sformatf("model_p0_rvalid@%0d", cyc), 32'(p0_rvalid), 32'(dueValid[s] && duePort[s] == 0));
            checkOutput($sformatf("model_p1_rvalid@%0d", cyc), 32'(p1_rvalid), 32'(dueValid[s] && duePort[s] == 1));
            if (dueValid[s]) begin
                checkOutput($sformatf("model_rdata@%0d", cyc), rdata, dueData[s]);
            end
            dueValid[s] = 1'b0;

            if (rst) begin
                mOwner = -1;
                mPtr = 0;
                for (int k = 0; k < 8; k++) dueValid[k] = 1'b0;
                expCs = 1'b1; expWr = 1'b0; expOe = 1'b0;
                expAddr = '0; expWdata = '0;
            end else begin
                if (eg0 || eg1) begin
                    g = eg1 ? 1 : 0;
                    expCs = 1'b0;
                    expWr = g ? p1_we : p0_we;
                    expOe = expWr;
                    expAddr = g ? p1_addr : p0_addr;
                    expWdata = g ? p1_wdata : p0_wdata;
                    if (expWr) begin
                        shadow[expAddr] = expWdata;
                    end else begin
                        dueValid[(cyc + 3) % 8] = 1'b1;
                        duePort[(cyc + 3) % 8] = g;
                        dueData[(cyc + 3) % 8] = shadow[expAddr];
                    end
                    mPtr = 1 - g;
                end else begin
                    expCs = 1'b1; expWr = 1'b0; expOe = 1'b0;
                end
                if (mOwner == -1) begin
                    if (eg0 && p0_lock)      mOwner = 0;
                    else if (eg1 && p1_lock) mOwner = 1;
                end else if (mOwner == 0) begin
                    if (!p0_req || !p0_lock) mOwner = -1;
                end else begin
                    if (!p1_req || !p1_lock) mOwner = -1;
                end
            end
            cyc++;
        end
    end

    task automatic applyStimulus(input logic r0, input logic we0, input logic lk0,
                                 input logic [9:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic we1, input logic lk1,
                                 input logic [9:0] a1, input logic [31:0] d1);
        p0_req = r0; p0_we = we0; p0_lock = lk0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = we1; p1_lock = lk1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(0, 0, 0, 10'h0, 32'h0, 0, 0, 0, 10'h0, 32'h0);
        repeat (n) nextCycle();
    endtask

    initial begin
        int p1Wins;
        int p0Wins;
        for (int i = 0; i < 8; i++) dueValid[i] = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            tbMem[i] = initWord(i);
            shadow[i] = initWord(i);
        end
        rst = 1'b1;
        applyStimulus(1, 0, 0, 10'h000, 32'h0, 1, 0, 0, 10'h001, 32'h0);
        nextCycle();

        // Reset held two cycles with both ports requesting.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst_p0_gnt", 32'(p0_gnt), 32'd0);
            checkOutput("rst_p1_gnt", 32'(p1_gnt), 32'd0);
            checkOutput("rst_mem_CS", 32'(mem_CS), 32'd1);
            checkOutput("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
            checkOutput("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
            nextCycle();
        end
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_p0_first", 32'(p0_gnt), 32'd1);
        checkOutput("post_rst_p1_waits", 32'(p1_gnt), 32'd0);
        nextCycle();
        idleCycles(4);

        // Single write from p1.
        applyStimulus(0, 0, 0, 10'h0, 32'h0, 1, 1, 0, 10'h014, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("wr_p1_gnt", 32'(p1_gnt), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 10'h0, 32'h0, 0, 0, 0, 10'h0, 32'h0);
        @(negedge clk);
        checkOutput("wr_mem_CS", 32'(mem_CS), 32'd0);
        checkOutput("wr_mem_WR", 32'(mem_WR), 32'd1);
        checkOutput("wr_mem_oe", 32'(mem_oe), 32'd1);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'h014);
        checkOutput("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        nextCycle();
        @(negedge clk);
        checkOutput("wr_mem_word20", tbMem[20], 32'hDEADBEEF);
        nextCycle();

        // Read-back from p0: rvalid only at T+3.
        applyStimulus(1, 0, 0, 10'h014, 32'h0, 0, 0, 0, 10'h0, 32'h0);
        @(negedge clk);
        checkOutput("rd_p0_gnt", 32'(p0_gnt), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 10'h0, 32'h0, 0, 0, 0, 10'h0, 32'h0);
        @(negedge clk);
        checkOutput("rd_p0_rvalid_t1", 32'(p0_rvalid), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rd_p0_rvalid_t2", 32'(p0_rvalid), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rd_p0_rvalid_t3", 32'(p0_rvalid), 32'd1);
        checkOutput("rd_rdata_t3", rdata, 32'hDEADBEEF);
        checkOutput("rd_p1_rvalid_t3", 32'(p1_rvalid), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rd_p0_rvalid_t4", 32'(p0_rvalid), 32'd0);
        nextCycle();

        // p1 write steers the pointer back to p0 before contention.
        applyStimulus(0, 0, 0, 10'h0, 32'h0, 1, 1, 0, 10'h020, 32'h12345678);
        nextCycle();
        idleCycles(3);

        // Contention: alternating grants and alternating read returns.
        applyStimulus(1, 0, 0, 10'h000, 32'h0, 1, 0, 0, 10'h001, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("cont_p0_gnt_%0d", i), 32'(p0_gnt), 32'(i % 2 == 0));
            checkOutput($sformatf("cont_p1_gnt_%0d", i), 32'(p1_gnt), 32'(i % 2 == 1));
            if (i >= 3) begin
                checkOutput($sformatf("cont_p0_rvalid_%0d", i), 32'(p0_rvalid), 32'((i - 3) % 2 == 0));
                checkOutput($sformatf("cont_p1_rvalid_%0d", i), 32'(p1_rvalid), 32'((i - 3) % 2 == 1));
            end
            nextCycle();
        end
        idleCycles(5);

        // Lock: p0 keeps ownership for 20 reads while p1 waits.
        applyStimulus(1, 0, 1, 10'h100, 32'h0, 0, 0, 0, 10'h0, 32'h0);
        @(negedge clk);
        checkOutput("lock_first_p0_gnt", 32'(p0_gnt), 32'd1);
        nextCycle();
        p1Wins = 0;
        p0Wins = 0;
        for (int i = 1; i < 20; i++) begin
            applyStimulus(1, 0, 1, 10'h100 + 10'(i), 32'h0, 1, 0, 0, 10'h200, 32'h0);
            @(negedge clk);
            if (p1_gnt) p1Wins++;
            if (p0_gnt) p0Wins++;
            nextCycle();
        end
        checkOutput("lock_p1_wins", 32'(p1Wins), 32'd0);
        checkOutput("lock_p0_wins", 32'(p0Wins), 32'd19);
        applyStimulus(1, 0, 0, 10'h114, 32'h0, 1, 0, 0, 10'h200, 32'h0);
        @(negedge clk);
        checkOutput("unlock_p0_gnt", 32'(p0_gnt), 32'd1);
        checkOutput("unlock_p1_gnt", 32'(p1_gnt), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("after_unlock_p1_gnt", 32'(p1_gnt), 32'd1);
        checkOutput("after_unlock_p0_gnt", 32'(p0_gnt), 32'd0);
        nextCycle();
        idleCycles(5);

        // Owner drops its request: ownership released, in-flight read still returns.
        applyStimulus(1, 0, 1, 10'h014, 32'h0, 0, 0, 0, 10'h0, 32'h0);
        @(negedge clk);
        checkOutput("drop_p0_gnt", 32'(p0_gnt), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 10'h0, 32'h0, 1, 1, 0, 10'h030, 32'hCAFEF00D);
        @(negedge clk);
        checkOutput("drop_p1_blocked", 32'(p1_gnt), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("drop_p1_gnt", 32'(p1_gnt), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 10'h0, 32'h0, 0, 0, 0, 10'h0, 32'h0);
        @(negedge clk);
        checkOutput("drop_p0_rvalid", 32'(p0_rvalid), 32'd1);
        checkOutput("drop_rdata", rdata, 32'hDEADBEEF);
        nextCycle();
        idleCycles(4);

        // Reset one cycle after a read grant discards the read.
        applyStimulus(1, 0, 0, 10'h030, 32'h0, 0, 0, 0, 10'h0, 32'h0);
        @(negedge clk);
        checkOutput("rstmid_p0_gnt", 32'(p0_gnt), 32'd1);
        nextCycle();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 10'h0, 32'h0, 1, 0, 0, 10'h001, 32'h0);
        @(negedge clk);
        checkOutput("rstmid_p1_gnt_forced", 32'(p1_gnt), 32'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 10'h0, 32'h0, 0, 0, 0, 10'h0, 32'h0);
        @(negedge clk);
        checkOutput("rstmid_mem_CS", 32'(mem_CS), 32'd1);
        checkOutput("rstmid_rdata", rdata, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("rstmid_p0_rvalid", 32'(p0_rvalid), 32'd0);
        nextCycle();
        applyStimulus(1, 0, 0, 10'h030, 32'h0, 1, 0, 0, 10'h014, 32'h0);
        @(negedge clk);
        checkOutput("rstmid_ptr_p0_first", 32'(p0_gnt), 32'd1);
        nextCycle();
        idleCycles(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
